// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned SCAN_DIV_DEF     = 10_000;
    localparam int unsigned DEBOUNCE_CNT_DEF = 100_000;
    localparam int unsigned REPEAT_DELAY_DEF = 5_000_000;
    localparam int unsigned REPEAT_RATE_DEF  = 1_000_000;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_SCAN      = 2'd0;
    localparam state_t ST_DEB_PRESS = 2'd1;
    localparam state_t ST_HELD      = 2'd2;
    localparam state_t ST_DEB_REL   = 2'd3;

    // Nibble i holds the hex code for key {r,c} = i; '*' -> E, '#' -> F.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } row_hit_t;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [5:0] base;
        base = {r, c, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

    // Exactly one row low is a candidate key; none or several low is ignored.
    function automatic row_hit_t decode_row(input logic [3:0] rows);
        row_hit_t hit;
        hit = '0;
        case (rows)
            4'b1110: hit = '{valid: 1'b1, idx: 2'd0};
            4'b1101: hit = '{valid: 1'b1, idx: 2'd1};
            4'b1011: hit = '{valid: 1'b1, idx: 2'd2};
            4'b0111: hit = '{valid: 1'b1, idx: 2'd3};
            default: hit = '0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up keypad rows.
module keypad_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan FSM with press/release debounce and a one-cycle key strobe.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = SCAN_DIV_DEF,
    parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_err
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0]       rows_s;
    state_t           state_q, state_d;
    logic [1:0]       c_q, c_d;
    logic [1:0]       row_q, row_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       col_out_d;
    logic [3:0]       key_code_d;
    logic             key_valid_d;
    logic             key_held_d;
    logic             rep_fire;

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (rows_s)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_lim;
    logic             rep_phase_q;

    // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
    assign rep_lim  = rep_phase_q ? REP_W'(REPEAT_RATE - 1) : REP_W'(REPEAT_DELAY - 1);
    assign rep_fire = ena && (state_q == ST_HELD) && (rows_s != 4'b1111) && (rep_q >= rep_lim);

    // Repeat timer: runs in HELD, frozen in DEB_REL, cleared elsewhere.
    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            rep_q       <= '0;
            rep_phase_q <= 1'b0;
        end else if (state_q != ST_HELD && state_q != ST_DEB_REL) begin
            rep_q       <= '0;
            rep_phase_q <= 1'b0;
        end else if (rep_fire) begin
            rep_q       <= '0;
            rep_phase_q <= 1'b1;
        end else if (state_q == ST_HELD && rows_s != 4'b1111 && rep_q != REP_W'(REP_MAX)) begin
            rep_q <= rep_q + REP_W'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_SCAN;
            c_q       <= 2'd0;
            row_q     <= 2'd0;
            div_q     <= '0;
            deb_q     <= '0;
            col_out   <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            row_q     <= row_d;
            div_q     <= div_d;
            deb_q     <= deb_d;
            col_out   <= col_out_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_held  <= key_held_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        logic             sample_pt;
        logic             deb_last;
        logic [DEB_W-1:0] deb_inc;
        logic [3:0]       row_mask;
        row_hit_t         hit;

        state_d     = state_q;
        c_d         = c_q;
        row_d       = row_q;
        div_d       = div_q;
        deb_d       = deb_q;
        key_code_d  = key_code;
        key_valid_d = 1'b0;
        key_held_d  = 1'b0;
        col_out_d   = col_out;

        sample_pt = (div_q == DIV_W'(SCAN_DIV - 1));
        deb_last  = (deb_q == DEB_W'(DEBOUNCE_CNT - 1));
        deb_inc   = (deb_q == DEB_W'(DEBOUNCE_CNT)) ? deb_q : deb_q + DEB_W'(1);
        row_mask  = ~(4'b0001 << row_q);
        hit       = decode_row(rows_s);

        case (state_q)
            ST_SCAN: begin
                div_d = sample_pt ? '0 : div_q + DIV_W'(1);
                if (sample_pt) begin
                    if (hit.valid) begin
                        state_d = ST_DEB_PRESS;
                        row_d   = hit.idx;
                        deb_d   = '0;
                    end else begin
                        c_d = c_q + 2'd1;
                    end
                end
            end
            ST_DEB_PRESS: begin
                div_d = '0;
                if (rows_s == row_mask) begin
                    if (deb_last) begin
                        state_d     = ST_HELD;
                        key_code_d  = key_lookup(row_q, c_q);
                        key_valid_d = 1'b1;
                        deb_d       = '0;
                    end else begin
                        deb_d = deb_inc;
                    end
                end else begin
                    state_d = ST_SCAN;
                    deb_d   = '0;
                end
            end
            ST_HELD: begin
                div_d = '0;
                if (rows_s == 4'b1111) begin
                    state_d = ST_DEB_REL;
                    deb_d   = '0;
                end else if (rep_fire) begin
                    key_valid_d = 1'b1;
                end
            end
            ST_DEB_REL: begin
                div_d = '0;
                if (rows_s == 4'b1111) begin
                    if (deb_last) begin
                        state_d = ST_SCAN;
                        c_d     = c_q + 2'd1;
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_inc;
                    end
                end else begin
                    state_d = ST_HELD;
                    deb_d   = '0;
                end
            end
            default: begin
                state_d = ST_SCAN;
                div_d   = '0;
                deb_d   = '0;
            end
        endcase

        // Disable parks the scanner on column 0 but keeps the last key code.
        if (!ena) begin
            state_d     = ST_SCAN;
            c_d         = 2'd0;
            div_d       = '0;
            deb_d       = '0;
            key_valid_d = 1'b0;
        end

        key_held_d = (state_d == ST_HELD) || (state_d == ST_DEB_REL);
        col_out_d  = ~(4'b0001 << c_d);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 keypad matrix.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned DEBOUNCE_CNT = 8;
    localparam int unsigned REPEAT_DELAY = 20;
    localparam int unsigned REPEAT_RATE  = 6;
    // Slot start -> detecting sample point is SCAN_DIV-1 cycles; strobe follows DEBOUNCE_CNT+1 later.
    localparam int unsigned PRESS_LAT    = (SCAN_DIV - 1) + DEBOUNCE_CNT + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed = '0;
    logic        force_en = 1'b0;
    logic [3:0]  force_rows = 4'b1111;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] at;
    } exp_t;

    exp_t sb_q[$];

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
        if (force_en) row_in = force_rows;
    end

    function automatic logic [3:0] col_pat(input int c);
        return ~(4'b0001 << c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] pat, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (col_out == pat) ok = 1'b1;
        end
    endtask

    // Press so the key is seen from the first cycle of its column slot.
    task automatic press_strobe(input int r, input int c, input logic [3:0] code,
                                output int unsigned t0);
        logic ok;
        exp_t e;
        wait_col(col_pat((c + 3) % 4), ok);
        chk("wait_prev_col", 32'(ok), 1);
        pressed[r*4+c] = 1'b1;
        wait_col(col_pat(c), ok);
        chk("wait_key_col", 32'(ok), 1);
        t0     = cyc + PRESS_LAT;
        e.code = code;
        e.at   = t0;
        sb_q.push_back(e);
        while (cyc < t0) @(negedge clk);
        chk("held_at_accept", 32'(key_held), 1);
    endtask

    task automatic release_key(input int r, input int c);
        int unsigned m;
        pressed[r*4+c] = 1'b0;
        m = cyc;
        while (cyc < m + DEBOUNCE_CNT + 2) @(negedge clk);
        chk("held_during_release", 32'(key_held), 1);
        @(negedge clk);
        chk("held_fall", 32'(key_held), 0);
        chk("col_after_release", 32'(col_out), 32'(col_pat((c + 1) % 4)));
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && key_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: key_code=%0h at cycle %0d, none expected", key_code, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe_code", 32'(key_code), 32'(e.code));
                    chk("strobe_cycle", cyc, e.at);
                end
            end
        end
    endtask

    initial begin
        int unsigned t0;
        int unsigned n;
        logic        ok;
        exp_t        e;

        fork
            monitor();
            begin
                #200_000;
                $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset with all rows floating high.
        rst_n = 1'b0;
        ena   = 1'b1;
        tick(3);
        chk("reset_col_out", 32'(col_out), 32'h0000_000E);
        chk("reset_key_code", 32'(key_code), 0);
        chk("reset_key_valid", 32'(key_valid), 0);
        chk("reset_key_held", 32'(key_held), 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick((k == 0) ? 1 : 4);
            chk("scan_rotation", 32'(col_out), 32'(col_pat(k)));
        end

        // Clean press and release of '5'.
        press_strobe(1, 1, 4'h5, t0);
        tick(5);
        release_key(1, 1);
        chk("code_kept_after_release", 32'(key_code), 32'h5);

        // 3-cycle glitch on row0/col3, then a stable press of 'A'.
        wait_col(col_pat(2), ok);
        wait_col(col_pat(3), ok);
        pressed[3] = 1'b1;
        tick(3);
        pressed[3] = 1'b0;
        wait_col(col_pat(0), ok);
        chk("scan_resumes_after_glitch", 32'(ok), 1);
        press_strobe(0, 3, 4'hA, t0);
        tick(3);
        release_key(0, 3);

        // Ghosting: rows 0 and 2 low together must not stop the scan.
        wait_col(col_pat(3), ok);
        wait_col(col_pat(0), ok);
        force_rows = 4'b1010;
        force_en   = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick(4);
            chk("ghost_scan_rotation", 32'(col_out), 32'(col_pat(k)));
        end
        force_en = 1'b0;
        chk("ghost_not_held", 32'(key_held), 0);

        // Disable in the middle of press debounce.
        wait_col(col_pat(0), ok);
        pressed[5] = 1'b1;
        wait_col(col_pat(1), ok);
        n = cyc;
        while (cyc < n + SCAN_DIV + 2) @(negedge clk);
        ena = 1'b0;
        tick(1);
        chk("ena_low_col0", 32'(col_out), 32'h0000_000E);
        chk("ena_low_not_held", 32'(key_held), 0);
        chk("ena_low_code_kept", 32'(key_code), 32'hA);
        pressed[5] = 1'b0;
        tick(4);
        chk("ena_low_col_parked", 32'(col_out), 32'h0000_000E);
        ena = 1'b1;

        // Hold '#'; auto-repeat strobes only when the feature is built in.
        press_strobe(3, 2, 4'hF, t0);
`ifdef KEYPAD_AUTOREPEAT_EN
        e.code = 4'hF;
        e.at   = t0 + REPEAT_DELAY;
        sb_q.push_back(e);
        e.at   = t0 + REPEAT_DELAY + REPEAT_RATE;
        sb_q.push_back(e);
        e.at   = t0 + REPEAT_DELAY + 2 * REPEAT_RATE;
        sb_q.push_back(e);
`endif
        while (cyc < t0 + 33) @(negedge clk);
        release_key(3, 2);
        chk("code_after_hash", 32'(key_code), 32'hF);

        tick(20);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
